// File: rtl/composite_sync_gen.sv
// Composite sync generator. Each line or half-line it drives csync_n from one of
// four pulse types: hsync, pre-EQ, serration (SE) or post-EQ.
module composite_sync_gen #(
    parameter int unsigned HS_START             = 10,
    parameter int unsigned HALF_LINES_PER_PHASE = 6
) (
    input  logic       clk_dot4x,
    input  logic       rst,
    input  logic [1:0] chip,
    input  logic [9:0] raster_x,
    input  logic [8:0] raster_y,
    input  logic       SE,
    output logic       csync_n,
    output logic       hsync_n,
    output logic       vsync_active,
    output logic [1:0] vblank_phase
);

    localparam int unsigned XW  = 10;
    localparam int unsigned YW  = 9;
    localparam int unsigned HCW = 3;

    localparam logic [1:0] CHIP_R8   = 2'd0;
    localparam logic [1:0] CHIP_R56A = 2'd1;

    typedef enum logic [1:0] {
        ST_NORMAL  = 2'd0,
        ST_PRE_EQ  = 2'd1,
        ST_VSYNC   = 2'd2,
        ST_POST_EQ = 2'd3
    } state_t;

    state_t           r_state;
    logic [HCW-1:0]   r_hc;
    logic [XW-1:0]    r_rx_d;
    logic [1:0]       r_chip_d;
    logic             r_csync_n;
    logic             r_hsync_n;
    logic             r_vsync;

    logic [XW-1:0]    w_h;
    logic [XW-1:0]    w_w_hs;
    logic [XW-1:0]    w_w_eq;
    logic [YW-1:0]    w_vs_line;
    logic [XW-1:0]    w_line_lo;
    logic [XW-1:0]    w_half_lo;
    logic             w_hs_win;
    logic             w_eq_win;
    logic             w_hb_line;
    logic             w_hb_half;
    logic             w_hb;
    logic             w_last_hl;
    logic             w_chip_chg;
    logic             w_pulse;

    // Per-chip timing constants
    always_comb begin
        w_h       = XW'(252);
        w_w_hs    = XW'(36);
        w_w_eq    = XW'(18);
        w_vs_line = YW'(300);
        case (chip)
            CHIP_R8: begin
                w_h       = XW'(260);
                w_w_hs    = XW'(37);
                w_w_eq    = XW'(19);
                w_vs_line = YW'(11);
            end
            CHIP_R56A: begin
                w_h       = XW'(256);
                w_vs_line = YW'(11);
            end
            default: begin
            end
        endcase
    end

    assign w_line_lo = XW'(HS_START);
    assign w_half_lo = XW'(HS_START) + w_h;

    // Windows decode the delayed x so they line up with the already-lagging SE
    assign w_hs_win = (r_rx_d >= w_line_lo) && (r_rx_d < w_line_lo + w_w_hs);
    assign w_eq_win = ((r_rx_d >= w_line_lo) && (r_rx_d < w_line_lo + w_w_eq)) ||
                      ((r_rx_d >= w_half_lo) && (r_rx_d < w_half_lo + w_w_eq));

    // One strobe per 4-cycle hold: only the first cycle differs from the previous x
    assign w_hb_line  = (raster_x == w_line_lo) && (raster_x != r_rx_d);
    assign w_hb_half  = (raster_x == w_half_lo) && (raster_x != r_rx_d);
    assign w_hb       = w_hb_line || w_hb_half;
    assign w_last_hl  = (r_hc == HCW'(HALF_LINES_PER_PHASE - 1));
    assign w_chip_chg = (chip != r_chip_d);

    always_comb begin
        w_pulse = w_hs_win;
        case (r_state)
            ST_NORMAL:             w_pulse = w_hs_win;
            ST_PRE_EQ, ST_POST_EQ: w_pulse = w_eq_win;
            ST_VSYNC:              w_pulse = SE;
        endcase
    end

    // Vertical-interval sequencer plus registered outputs
    always_ff @(posedge clk_dot4x) begin
        if (rst) begin
            r_state   <= ST_NORMAL;
            r_hc      <= '0;
            r_rx_d    <= '0;
            r_chip_d  <= chip;
            r_csync_n <= 1'b1;
            r_hsync_n <= 1'b1;
            r_vsync   <= 1'b0;
        end else begin
            r_rx_d    <= raster_x;
            r_chip_d  <= chip;
            r_csync_n <= ~w_pulse;
            r_hsync_n <= ~w_hs_win;
            if (w_chip_chg && (r_state != ST_NORMAL)) begin
                r_state <= ST_NORMAL;
                r_hc    <= '0;
                r_vsync <= 1'b0;
            end else if (w_hb) begin
                case (r_state)
                    ST_NORMAL: begin
                        if (w_hb_line && (raster_y == w_vs_line)) begin
                            r_state <= ST_PRE_EQ;
                            r_hc    <= '0;
                        end
                    end
                    ST_PRE_EQ: begin
                        if (w_last_hl) begin
                            r_state <= ST_VSYNC;
                            r_hc    <= '0;
                            r_vsync <= 1'b1;
                        end else begin
                            r_hc <= r_hc + HCW'(1);
                        end
                    end
                    ST_VSYNC: begin
                        if (w_last_hl) begin
                            r_state <= ST_POST_EQ;
                            r_hc    <= '0;
                            r_vsync <= 1'b0;
                        end else begin
                            r_hc <= r_hc + HCW'(1);
                        end
                    end
                    ST_POST_EQ: begin
                        if (w_last_hl) begin
                            r_state <= ST_NORMAL;
                            r_hc    <= '0;
                        end else begin
                            r_hc <= r_hc + HCW'(1);
                        end
                    end
                endcase
            end
        end
    end

    assign csync_n      = r_csync_n;
    assign hsync_n      = r_hsync_n;
    assign vsync_active = r_vsync;
    assign vblank_phase = 2'(r_state);

endmodule
